// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with stall hold, a one-entry redirect buffer
// and a misalignment flag. Priority: jump > branch > buffered redirect > increment.
module pc_sequencer #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       OFF_W    = 16,
  parameter int unsigned       SHIFT    = 2,
  parameter int unsigned       INC      = 4,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned       JIDX_W   = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WIDTH-1:0]  branch_base,
  input  logic [OFF_W-1:0]  branch_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  pc_plus,
  output logic [WIDTH-1:0]  branch_target,
  output logic              fetch_valid,
  output logic              redirect_pending,
  output logic              misaligned
);

  // Masks replace bit-slicing so SHIFT=0 needs no zero-width concatenation.
  localparam logic [WIDTH-1:0] LOW_MASK  = ~({WIDTH{1'b1}} << SHIFT);
  localparam logic [WIDTH-1:0] HIGH_MASK = {WIDTH{1'b1}} << (JIDX_W + SHIFT);

  logic [WIDTH-1:0] offsetExt;
  logic [WIDTH-1:0] jumpTarget;
  logic [WIDTH-1:0] reqTarget;
  logic             req;
  logic [WIDTH-1:0] pendTarget;

  logic [WIDTH-1:0] nextPc;
  logic [WIDTH-1:0] nextPendTarget;
  logic             nextPending;
  logic             nextMisaligned;

  assign pc_plus       = pc + WIDTH'(INC);
  assign offsetExt     = {{(WIDTH-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
  assign branch_target = branch_base + (offsetExt << SHIFT);
  assign jumpTarget    = (pc_plus & HIGH_MASK) | ((WIDTH'(jump_index) << SHIFT) & ~HIGH_MASK);
  assign req           = jump | branch_taken;
  assign reqTarget     = jump ? jumpTarget : branch_target;

  always_comb begin
    nextPc         = pc;
    nextPendTarget = pendTarget;
    nextPending    = redirect_pending;
    nextMisaligned = misaligned;
    if (!stall) begin
      if (req) begin
        nextPc         = reqTarget;
        nextPending    = 1'b0;
        nextPendTarget = '0;
        nextMisaligned = |(reqTarget & LOW_MASK);
      end else if (redirect_pending) begin
        nextPc         = pendTarget;
        nextPending    = 1'b0;
        nextPendTarget = '0;
        nextMisaligned = |(pendTarget & LOW_MASK);
      end else begin
        nextPc         = pc_plus;
        nextMisaligned = 1'b0;
      end
    end else if (req) begin
      // Youngest stalled request overwrites any older buffered one.
      nextPendTarget = reqTarget;
      nextPending    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc               <= RESET_PC;
      pendTarget       <= '0;
      redirect_pending <= 1'b0;
      misaligned       <= 1'b0;
      fetch_valid      <= 1'b0;
    end else begin
      pc               <= nextPc;
      pendTarget       <= nextPendTarget;
      redirect_pending <= nextPending;
      misaligned       <= nextMisaligned;
      fetch_valid      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a behavioural
// model of the next-PC rules, plus directed cases for the notable scenarios.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_base;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus, branch_target;
  logic        fetch_valid, redirect_pending, misaligned;

  logic [31:0] pcW, pcPlusW, branchTargetW;
  logic        fetchValidW, redirectPendingW, misalignedW;

  int unsigned nChecks = 0;
  int unsigned nPass   = 0;

  // Reference model state
  logic [31:0] mPc;
  logic [31:0] pendQ[$];
  logic        mMis;
  logic        mValid;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_base(branch_base), .branch_offset(branch_offset), .jump(jump),
    .jump_index(jump_index), .pc(pc), .pc_plus(pc_plus),
    .branch_target(branch_target), .fetch_valid(fetch_valid),
    .redirect_pending(redirect_pending), .misaligned(misaligned)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .reset(reset), .stall(1'b0), .branch_taken(1'b0),
    .branch_base(32'h0), .branch_offset(16'h0), .jump(1'b0),
    .jump_index(26'h0), .pc(pcW), .pc_plus(pcPlusW),
    .branch_target(branchTargetW), .fetch_valid(fetchValidW),
    .redirect_pending(redirectPendingW), .misaligned(misalignedW)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] refBranch(input logic [31:0] base, input logic [15:0] off);
    int o;
    o = $signed(off);
    return base + 32'(o * 4);
  endfunction

  function automatic logic [31:0] refJump(input logic [31:0] curPc, input logic [25:0] idx);
    logic [31:0] nxt;
    nxt = curPc + 32'd4;
    return (nxt & 32'hF000_0000) + 32'(idx) * 32'd4;
  endfunction

  task automatic modelReset();
    mPc = 32'h0;
    pendQ.delete();
    mMis = 1'b0;
    mValid = 1'b0;
  endtask

  task automatic checkState(input string tag);
    checkVal({tag, ".pc"}, pc, mPc);
    checkVal({tag, ".pc_plus"}, pc_plus, mPc + 32'd4);
    checkVal({tag, ".pending"}, 32'(redirect_pending), 32'(pendQ.size() != 0));
    checkVal({tag, ".misaligned"}, 32'(misaligned), 32'(mMis));
    checkVal({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(mValid));
  endtask

  // One clock cycle: drive inputs, check the combinational target, advance model and DUT.
  task automatic step(input string tag, input logic s, input logic bt, input logic j,
                      input logic [31:0] base, input logic [15:0] off, input logic [25:0] idx);
    logic [31:0] tgt;
    stall = s; branch_taken = bt; jump = j;
    branch_base = base; branch_offset = off; jump_index = idx;
    #1;
    checkVal({tag, ".branch_target"}, branch_target, refBranch(base, off));
    tgt = j ? refJump(mPc, idx) : refBranch(base, off);
    @(posedge clk);
    mValid = 1'b1;
    if (!s) begin
      if (j || bt) begin
        mPc = tgt;
        pendQ.delete();
        mMis = (tgt % 4) != 0;
      end else if (pendQ.size() != 0) begin
        mPc = pendQ.pop_front();
        mMis = (mPc % 4) != 0;
      end else begin
        mPc = mPc + 32'd4;
        mMis = 1'b0;
      end
    end else if (j || bt) begin
      pendQ.delete();
      pendQ.push_back(tgt);
    end
    #1;
    checkState(tag);
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_base = '0; branch_offset = '0; jump_index = '0;
    modelReset();
    #12;
    checkState("reset");
    checkVal("wrap.reset_pc", pcW, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Sequential run from reset
    step("seq0", 0, 0, 0, 32'h0, 16'h0, 26'h0);
    checkVal("wrap.pc_after", pcW, 32'h0000_0000);
    checkVal("seq0.pc_const", pc, 32'h4);
    step("seq1", 0, 0, 0, 32'h0, 16'h0, 26'h0);
    step("seq2", 0, 0, 0, 32'h0, 16'h0, 26'h0);
    checkVal("seq2.pc_const", pc, 32'hC);

    // Forward branch, then sequential
    step("br", 0, 1, 0, 32'h4, 16'h0110, 26'h0);
    checkVal("br.pc_const", pc, 32'h444);
    step("br_next", 0, 0, 0, 32'h0, 16'h0, 26'h0);
    checkVal("br_next.pc_const", pc, 32'h448);

    // Negative offset
    step("neg", 0, 1, 0, 32'h100, 16'hFFFF, 26'h0);
    checkVal("neg.pc_const", pc, 32'hFC);

    // Misaligned target, cleared by the next increment
    step("mis", 0, 1, 0, 32'h1, 16'h0110, 26'h0);
    checkVal("mis.flag_const", 32'(misaligned), 32'h1);
    step("mis_clr", 0, 0, 0, 32'h0, 16'h0, 26'h0);

    // Stall buffering: get pc to 0x20, then two stalled requests
    step("j20", 0, 0, 1, 32'h0, 16'h0, 26'h8);
    checkVal("j20.pc_const", pc, 32'h20);
    step("st1", 1, 1, 0, 32'h40, 16'h0010, 26'h0);
    step("st2", 1, 0, 1, 32'h0, 16'h0, 26'h40);
    step("st3", 1, 0, 0, 32'h0, 16'h0, 26'h0);
    checkVal("st3.hold_const", pc, 32'h20);
    step("unst", 0, 0, 0, 32'h0, 16'h0, 26'h0);
    checkVal("unst.pc_const", pc, 32'h100);

    // Simultaneous jump and branch: jump wins
    step("both", 0, 1, 1, 32'h1000, 16'h0004, 26'h123);

    // Asynchronous reset while a redirect is buffered
    step("pend", 1, 1, 0, 32'h2000, 16'h0008, 26'h0);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkState("async_rst");
    #2 reset = 1'b0;
    step("post_rst", 0, 0, 0, 32'h0, 16'h0, 26'h0);
    checkVal("post_rst.pc_const", pc, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic s, bt, j;
      s  = ($urandom_range(0, 2) == 0);
      bt = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 6) == 0);
      step("rand", s, bt, j, $urandom, 16'($urandom), 26'($urandom));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got 1 expected 0");
    $display("%0d/%0d checks passed", nPass, nChecks + 1);
    $fatal(1);
  end

endmodule
